regfile_multiport: RTL and testbench

//   Parametrised successor to the 2-read/1-write register file for the datapath.

---
 rtl/rf_pkg.sv | 10 +
 rtl/rf_clear_seq.sv | 40 ++++
 rtl/regfile_multiport.sv | 56 +++++
 tb/tb_regfile_multiport.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared state type and sizing helpers for the multiport register file
package rf_pkg;
    typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;
    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction
    localparam int RF_ADDR_W = 5;
    // A ZERO_REG at or beyond DEPTH disables the hardwired zero register
    localparam int RF_NO_ZERO = rf_depth(RF_ADDR_W);
endpackage

// File: rtl/rf_clear_seq.sv
// rf_clear_seq: post-reset clear FSM, clear address counter, busy and dropped-write pulse
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              i_reg_wr,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr,
    output logic              o_busy,
    output logic              o_wr_drop
);
    rf_state_t         r_state;
    rf_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_clr_idx;
    logic [ADDR_W-1:0] w_clr_idx_nxt;
    logic              r_wr_drop;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= RF_CLEAR;
            r_clr_idx <= '0;
            r_wr_drop <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
            r_wr_drop <= (r_state == RF_CLEAR) && i_reg_wr;
        end
    end
    // The counter wraps to 0 on the final clear cycle, which is also the RUN transition
    always_comb begin
        w_state_nxt   = (r_state == RF_CLEAR && r_clr_idx == '1) ? RF_RUN : r_state;
        w_clr_idx_nxt = (r_state == RF_CLEAR) ? r_clr_idx + 1'b1 : '0;
    end
    assign o_busy     = (r_state == RF_CLEAR);
    assign o_clr_we   = o_busy;
    assign o_clr_addr = r_clr_idx;
    assign o_wr_drop  = r_wr_drop;
endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: NUM_READ combinational read ports, one write port, optional zero register and bypass
module regfile_multiport
    import rf_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [NUM_READ*ADDR_W-1:0] RA,
    output logic [NUM_READ*DATA_W-1:0] BusOut,
    input  logic [ADDR_W-1:0]          RW,
    input  logic [DATA_W-1:0]          BusW,
    input  logic                       RegWr,
    output logic                       Busy,
    output logic                       WrDrop
);
    localparam int                DEPTH     = rf_depth(ADDR_W);
    localparam bit                ZERO_EN   = (ZERO_REG >= 0) && (ZERO_REG < DEPTH);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ZERO_EN ? ADDR_W'(ZERO_REG) : '0;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_wr_en;
    rf_clear_seq #(.ADDR_W(ADDR_W)) u_clr (
        .Clk       (Clk),
        .Reset     (Reset),
        .i_reg_wr  (RegWr),
        .o_clr_we  (w_clr_we),
        .o_clr_addr(w_clr_addr),
        .o_busy    (Busy),
        .o_wr_drop (WrDrop)
    );
    assign w_wr_en = RegWr && !Busy && !(ZERO_EN && RW == ZERO_ADDR);
    // The array is left untouched on reset edges; the clear sequence zeroes it afterwards
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (w_clr_we)
                r_mem[w_clr_addr] <= '0;
            else if (w_wr_en)
                r_mem[RW] <= BusW;
        end
    end
    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        assign w_ra = RA[i*ADDR_W +: ADDR_W];
        assign BusOut[i*DATA_W +: DATA_W] =
            Busy                                  ? '0   :
            (ZERO_EN && w_ra == ZERO_ADDR)        ? '0   :
            (BYPASS != 0 && RegWr && RW == w_ra)  ? BusW :
                                                    r_mem[w_ra];
    end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: directed checks on a 4-port bypassing instance and a 2-port non-bypassing instance
module tb_regfile_multiport;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam logic [DW-1:0] V5 = 64'hDEAD_BEEF_0123_4567;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic RegWr = 1'b0;
    logic [4*AW-1:0] RA = '0;
    logic [AW-1:0] RW = '0;
    logic [DW-1:0] BusW = '0;
    logic [4*DW-1:0] out_a;
    logic [2*DW-1:0] out_b;
    logic busy_a, drop_a, busy_b, drop_b;
    int n_checks = 0;
    int n_fail = 0;
    always #5 Clk = ~Clk;
    regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(4), .ZERO_REG(31), .BYPASS(1)) dut_a (
        .Clk(Clk), .Reset(Reset), .RA(RA), .BusOut(out_a), .RW(RW), .BusW(BusW),
        .RegWr(RegWr), .Busy(busy_a), .WrDrop(drop_a)
    );
    regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(2), .ZERO_REG(31), .BYPASS(0)) dut_b (
        .Clk(Clk), .Reset(Reset), .RA(RA[2*AW-1:0]), .BusOut(out_b), .RW(RW), .BusW(BusW),
        .RegWr(RegWr), .Busy(busy_b), .WrDrop(drop_b)
    );
    function automatic logic [DW-1:0] v(input int i);
        return 64'hA5C3_0000_0000_0000 + 64'(i);
    endfunction
    task automatic tick;
        @(posedge Clk);
        #1;
    endtask
    task automatic test_reset;
        int cnt = 0;
        Reset = 1'b1;
        RegWr = 1'b0;
        tick;
        n_checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy: busy_a=%b busy_b=%b expected 1", busy_a, busy_b);
        end
        n_checks++;
        if (drop_a !== 1'b0 || drop_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drop: drop_a=%b drop_b=%b expected 0", drop_a, drop_b);
        end
        Reset = 1'b0;
        while (busy_a === 1'b1 && cnt < 100) begin
            tick;
            cnt++;
        end
        n_checks++;
        if (cnt != 32 || busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_len: busy cycles=%0d busy_b=%b expected 32 and 0", cnt, busy_b);
        end
        for (int a = 0; a < 32; a++) begin
            RA = {4{AW'(a)}};
            #1;
            n_checks++;
            if (out_a !== '0 || out_b !== '0) begin
                n_fail++;
                $display("FAIL cleared_read[%0d]: a=%h b=%h expected 0", a, out_a, out_b);
            end
        end
        tick;
    endtask
    task automatic test_bypass;
        RW = 5'd5;
        BusW = V5;
        RegWr = 1'b1;
        RA = {4{5'd5}};
        #1;
        n_checks++;
        if (out_a[DW-1:0] !== V5 || out_b[DW-1:0] !== '0) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: a=%h b=%h expected %h and 0", out_a[DW-1:0], out_b[DW-1:0], V5);
        end
        tick;
        RegWr = 1'b0;
        #1;
        n_checks++;
        if (out_a[DW-1:0] !== V5 || out_b[DW-1:0] !== V5) begin
            n_fail++;
            $display("FAIL write_next_cycle: a=%h b=%h expected %h", out_a[DW-1:0], out_b[DW-1:0], V5);
        end
    endtask
    task automatic test_zero;
        RW = 5'd31;
        BusW = '1;
        RegWr = 1'b1;
        RA = {5'd0, 5'd5, 5'd31, 5'd31};
        for (int ph = 0; ph < 2; ph++) begin
            #1;
            n_checks++;
            if (out_a !== {64'd0, V5, 64'd0, 64'd0} || out_b !== '0) begin
                n_fail++;
                $display("FAIL zero_reg[%0d]: a=%h b=%h expected %h and 0", ph, out_a, out_b, {64'd0, V5, 64'd0, 64'd0});
            end
            tick;
            RegWr = 1'b0;
        end
    endtask
    task automatic test_multi;
        for (int i = 1; i <= 4; i++) begin
            RW = AW'(i);
            BusW = v(i);
            RegWr = 1'b1;
            tick;
        end
        RW = 5'd7;
        BusW = v(7);
        tick;
        RegWr = 1'b0;
        RA = {5'd4, 5'd3, 5'd2, 5'd1};
        #1;
        for (int p = 0; p < 4; p++) begin
            n_checks++;
            if (out_a[p*DW +: DW] !== v(p + 1)) begin
                n_fail++;
                $display("FAIL multi_port[%0d]: got %h expected %h", p, out_a[p*DW +: DW], v(p + 1));
            end
        end
        n_checks++;
        if (out_b !== {v(2), v(1)}) begin
            n_fail++;
            $display("FAIL multi_port_b: got %h expected %h", out_b, {v(2), v(1)});
        end
        RA = {4{5'd7}};
        #1;
        n_checks++;
        if (out_a !== {4{v(7)}} || out_b !== {2{v(7)}}) begin
            n_fail++;
            $display("FAIL same_addr: a=%h b=%h expected all %h", out_a, out_b, v(7));
        end
        tick;
    endtask
    task automatic test_back_to_back;
        RA = {5'd0, 5'd0, 5'd11, 5'd10};
        RW = 5'd10;
        BusW = v(10);
        RegWr = 1'b1;
        #1;
        n_checks++;
        if (out_a[DW-1:0] !== v(10) || out_b[DW-1:0] !== '0) begin
            n_fail++;
            $display("FAIL b2b_first: a=%h b=%h expected %h and 0", out_a[DW-1:0], out_b[DW-1:0], v(10));
        end
        tick;
        RW = 5'd11;
        BusW = v(11);
        #1;
        n_checks++;
        if (out_a[2*DW-1:0] !== {v(11), v(10)} || out_b !== {64'd0, v(10)}) begin
            n_fail++;
            $display("FAIL b2b_second: a=%h b=%h expected %h and %h", out_a[2*DW-1:0], out_b, {v(11), v(10)}, {64'd0, v(10)});
        end
        tick;
        RegWr = 1'b0;
        #1;
        n_checks++;
        if (out_b !== {v(11), v(10)}) begin
            n_fail++;
            $display("FAIL b2b_after: b=%h expected %h", out_b, {v(11), v(10)});
        end
    endtask
    task automatic test_drop;
        int cnt = 0;
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        repeat (10) tick;
        RegWr = 1'b1;
        RW = 5'd3;
        BusW = v(3);
        RA = {4{5'd3}};
        #1;
        n_checks++;
        if (drop_a !== 1'b0 || out_a !== '0 || out_b !== '0) begin
            n_fail++;
            $display("FAIL drop_pre: drop=%b a=%h b=%h expected 0", drop_a, out_a, out_b);
        end
        tick;
        RegWr = 1'b0;
        #1;
        n_checks++;
        if (drop_a !== 1'b1 || drop_b !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_pulse: drop_a=%b drop_b=%b expected 1", drop_a, drop_b);
        end
        tick;
        n_checks++;
        if (drop_a !== 1'b0 || drop_b !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_end: drop_a=%b drop_b=%b expected 0", drop_a, drop_b);
        end
        while (busy_a === 1'b1 && cnt < 100) begin
            tick;
            cnt++;
        end
        n_checks++;
        if (busy_a !== 1'b0 || out_a !== '0 || out_b !== '0) begin
            n_fail++;
            $display("FAIL drop_reg3: busy=%b a=%h b=%h expected 0", busy_a, out_a, out_b);
        end
    endtask
    task automatic test_reset_mid;
        int cnt = 0;
        RW = 5'd25;
        BusW = v(25);
        RegWr = 1'b1;
        tick;
        RegWr = 1'b0;
        RA = {4{5'd25}};
        #1;
        n_checks++;
        if (out_a[DW-1:0] !== v(25)) begin
            n_fail++;
            $display("FAIL mid_prewrite: got %h expected %h", out_a[DW-1:0], v(25));
        end
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        repeat (20) tick;
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        while (busy_a === 1'b1 && cnt < 100) begin
            tick;
            cnt++;
        end
        n_checks++;
        if (cnt != 32) begin
            n_fail++;
            $display("FAIL mid_restart_len: busy cycles=%0d expected 32", cnt);
        end
        n_checks++;
        if (out_a !== '0 || out_b !== '0) begin
            n_fail++;
            $display("FAIL mid_cleared: a=%h b=%h expected 0", out_a, out_b);
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        test_reset;
        test_bypass;
        test_zero;
        test_multi;
        test_back_to_back;
        test_drop;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
